// File: rtl/bel_fft_scale_ctrl_if.sv
// Handshake and status bundle between the FFT sequencer (master) and the
// block-floating-point scaling scheduler (slave).
interface bel_fft_scale_ctrl_if #(
    parameter int word_width  = 16,
    parameter int stage_width = 4,
    parameter int exp_width   = 6
);
    logic                   start_i;
    logic [stage_width-1:0] num_stages_i;
    logic                   smp_vld_i;
    logic [word_width-1:0]  smp_re_i;
    logic [word_width-1:0]  smp_im_i;
    logic                   pass_done_i;
    logic [1:0]             scale_o;
    logic                   scale_vld_o;
    logic [stage_width-1:0] stage_o;
    logic [exp_width-1:0]   exp_o;
    logic                   busy_o;
    logic                   done_o;

    modport master (
        output start_i, num_stages_i, smp_vld_i, smp_re_i, smp_im_i, pass_done_i,
        input  scale_o, scale_vld_o, stage_o, exp_o, busy_o, done_o
    );

    modport slave (
        input  start_i, num_stages_i, smp_vld_i, smp_re_i, smp_im_i, pass_done_i,
        output scale_o, scale_vld_o, stage_o, exp_o, busy_o, done_o
    );
endinterface

// File: rtl/bel_fft_scale_ctrl.sv
// Block-floating-point scaling scheduler: tracks per-pass minimum headroom of
// written-back samples and issues the next stage's right-shift plus block exponent.
module bel_fft_scale_ctrl #(
    parameter int word_width  = 16,
    parameter int guard_bits  = 2,
    parameter int stage_width = 4,
    parameter int exp_width   = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    bel_fft_scale_ctrl_if.slave  bus
);
    localparam int              HW    = $clog2(word_width);
    localparam logic [HW-1:0]   H_MAX = HW'(word_width - 1);
    localparam logic [HW-1:0]   GUARD = HW'(guard_bits);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DECIDE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [stage_width-1:0] n_q, n_d;
    logic [stage_width-1:0] cnt_q, cnt_d;
    logic [HW-1:0]          h_min_q, h_min_d;
    logic [1:0]             scale_q, scale_d;
    logic                   scale_vld_q, scale_vld_d;
    logic [stage_width-1:0] stage_q, stage_d;
    logic [exp_width-1:0]   exp_q, exp_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [HW-1:0]          h_smp_s;
    logic [HW-1:0]          h_pass_s;
    logic [1:0]             shift_s;

    // Redundant sign bits below the MSB.
    function automatic logic [HW-1:0] headroom(input logic [word_width-1:0] x);
        logic [HW-1:0] cnt;
        logic          run;
        cnt = '0;
        run = 1'b1;
        for (int i = word_width - 2; i >= 0; i--) begin
            if (run && (x[i] == x[word_width-1])) begin
                cnt = cnt + HW'(1);
            end else begin
                run = 1'b0;
            end
        end
        return cnt;
    endfunction

    function automatic logic [HW-1:0] min_h(input logic [HW-1:0] a, input logic [HW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Headroom of the current pass including a sample arriving with pass_done.
    always_comb begin
        h_smp_s = min_h(headroom(bus.smp_re_i), headroom(bus.smp_im_i));
        if (bus.smp_vld_i) begin
            h_pass_s = min_h(h_min_q, h_smp_s);
        end else begin
            h_pass_s = h_min_q;
        end
        if (h_pass_s < GUARD) begin
            shift_s = 2'(GUARD - h_pass_s);
        end else begin
            shift_s = 2'd0;
        end
    end

    // Next-state and output decision logic.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        h_min_d     = h_min_q;
        scale_d     = scale_q;
        scale_vld_d = 1'b0;
        stage_d     = stage_q;
        exp_d       = exp_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    n_d     = (bus.num_stages_i == '0) ? stage_width'(1) : bus.num_stages_i;
                    cnt_d   = '0;
                    exp_d   = '0;
                    stage_d = '0;
                    h_min_d = H_MAX;
                    busy_d  = 1'b1;
                    state_d = ST_SCAN;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_SCAN: begin
                if (bus.pass_done_i) begin
                    // Decision is registered here so it is visible during DECIDE.
                    if (cnt_q < n_q) begin
                        scale_d     = shift_s;
                        scale_vld_d = 1'b1;
                        stage_d     = cnt_q;
                        exp_d       = exp_q + exp_width'(shift_s);
                        cnt_d       = cnt_q + stage_width'(1);
                        busy_d      = 1'b1;
                    end else begin
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                    end
                    h_min_d = H_MAX;
                    state_d = ST_DECIDE;
                end else begin
                    h_min_d = h_pass_s;
                end
            end
            ST_DECIDE: begin
                if (busy_q) begin
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            cnt_q       <= '0;
            h_min_q     <= H_MAX;
            scale_q     <= 2'd0;
            scale_vld_q <= 1'b0;
            stage_q     <= '0;
            exp_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            h_min_q     <= h_min_d;
            scale_q     <= scale_d;
            scale_vld_q <= scale_vld_d;
            stage_q     <= stage_d;
            exp_q       <= exp_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.scale_o     = scale_q;
    assign bus.scale_vld_o = scale_vld_q;
    assign bus.stage_o     = stage_q;
    assign bus.exp_o       = exp_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
endmodule

// File: doc/bel_fft_scale_ctrl.md
Name: bel_fft_scale_ctrl

Overview:
- Block-floating-point scaling scheduler for the radix-4 FFT datapath.
- Monitors the samples written back after each pass and finds the minimum headroom (redundant sign bits) across re/im.
- Decides the right-shift (0, 1 or 2 bits; 2 = the rounded divide-by-4 path) that the butterflies apply in the next stage, and accumulates the frame's block exponent.
- Sits between the FFT sequencer (which owns passes and memory) and the butterfly scaling select.

Parameters:
- word_width, 16, sample component width in bits.
- guard_bits, 2, required headroom before a stage; legal 0..2; also the maximum shift.
- stage_width, 4, width of num_stages_i and stage_o.
- exp_width, 6, width of exp_o; must hold 2*(2^stage_width-1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  frame start pulse; accepted only in IDLE.
- num_stages_i  in  stage_width  number of radix-4 stages N (1..15); sampled on accepted start_i.
- smp_vld_i  in  1  qualifies smp_re_i/smp_im_i as a written-back sample of the current pass.
- smp_re_i  in  word_width  signed real part.
- smp_im_i  in  word_width  signed imaginary part.
- pass_done_i  in  1  pulse: last sample of the current pass has been presented.
- scale_o  out  2  shift for the next stage (0, 1 or 2); held between decisions.
- scale_vld_o  out  1  one-cycle pulse when scale_o is updated.
- stage_o  out  stage_width  index of the stage scale_o applies to.
- exp_o  out  exp_width  accumulated shift total for the frame.
- busy_o  out  1  high outside IDLE.
- done_o  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset: state IDLE. All outputs zero: scale_o=0, scale_vld_o=0, stage_o=0, exp_o=0, busy_o=0, done_o=0. Internal pass counter = 0; h_min = word_width-1.
- Headroom of a component x: count of consecutive bits from bit word_width-2 downward equal to bit word_width-1.
  - 0 and -1 give word_width-1.
  - 0x4000 gives 0.
- Per-sample headroom = min(re, im). h_min = min over all valid samples of the pass.
- State IDLE:
  - On start_i: latch N; clear pass counter, exp_o and stage_o; set h_min = word_width-1; go to SCAN.
  - pass_done_i and smp_vld_i are ignored in IDLE.
- State SCAN:
  - Each cycle with smp_vld_i, update h_min.
  - On pass_done_i go to DECIDE. A sample valid in the same cycle as pass_done_i is included in h_min.
  - start_i is ignored while busy.
- State DECIDE (exactly one cycle):
  - shift = guard_bits - h_min if h_min < guard_bits, else 0. Result is always 0..guard_bits.
  - If pass counter < N:
    - scale_o <= shift; scale_vld_o pulses.
    - stage_o <= pass counter.
    - exp_o <= exp_o + shift.
    - Increment pass counter; reset h_min to word_width-1; return to SCAN.
  - If pass counter == N (final stage output): no scale_vld_o; pulse done_o; go to IDLE. exp_o, scale_o and stage_o hold until the next start_i.
- Pass numbering:
  - Pass 0 is the input-load scan.
  - Pass k (1..N) is the output of stage k-1.
  - The decision after pass k drives stage k.
  - One frame produces exactly N scale_vld_o pulses and one done_o.
- Latency: pass_done_i in cycle t gives scale_vld_o or done_o in cycle t+1 (registered). The new pass's samples may start in cycle t+2.
  - smp_vld_i in cycle t+1 (DECIDE) is a protocol violation. It is ignored and does not enter either pass.
- Arithmetic:
  - exp_o never overflows for legal parameters; no saturation logic.
  - num_stages_i = 0 is treated as 1.
- rst_i mid-frame: in the next cycle the block is in IDLE with all outputs at reset values. No done_o is issued.
- busy_o is high in SCAN and DECIDE and drops in the cycle done_o is asserted.

Test Plan:
- Reset then idle: rst_i for 2 cycles; pulse pass_done_i and smp_vld_i without start_i -> all outputs remain 0, busy_o=0.
- Headroom mapping, N=1: pass 0 samples re=0x1000, im=0x0010 (h_min=2); pass_done_i -> next cycle scale_vld_o=1, scale_o=0, stage_o=0, exp_o=0. Then pass 1 with any data; pass_done_i -> done_o=1, exp_o=0.
- Full growth, N=3: pass 0 contains 0x4000 (h=0) -> scale 2. Pass 1 contains re=0xC000 (h=1) -> scale 1. Pass 2 contains im=0xE000 (h=2) -> scale 0. After pass 3 -> done_o. Check scale_o sequence 2,1,0; stage_o 0,1,2; final exp_o=3.
- Simultaneous events: sample 0x7FFF (h=0) presented with smp_vld_i in the same cycle as pass_done_i, all earlier samples 0 -> scale_o=2. start_i asserted while busy -> ignored, frame completes normally.
- Mid-frame reset: N=4, rst_i asserted after the second scale_vld_o -> next cycle IDLE with exp_o=0, busy_o=0, no done_o. A new start_i runs a clean frame from stage 0.
- guard_bits=1 build: pass sample 0x2000 (h=1) -> scale 0; pass sample 0x4000 (h=0) -> scale 1; scale_o never exceeds 1.
